// File: rtl/instrumented_adder_meas_ctrl_if.sv
// Handshake/config bundle between the LA/Wishbone config side and the measurement controller.
interface instrumented_adder_meas_ctrl_if #(parameter int GATE_W = 16);
  logic              active;
  logic              start;
  logic [31:0]       cfg_a;
  logic [31:0]       cfg_b;
  logic [GATE_W-1:0] cfg_gate;
  logic [31:0]       ring_cnt;
  logic [31:0]       adder_sum;
  logic [31:0]       adder_a;
  logic [31:0]       adder_b;
  logic              ring_en;
  logic              ring_cnt_clr;
  logic              busy;
  logic              done;
  logic [31:0]       result_count;
  logic [31:0]       result_sum;
  logic              err_stall;

  modport master (
    output active, start, cfg_a, cfg_b, cfg_gate, ring_cnt, adder_sum,
    input  adder_a, adder_b, ring_en, ring_cnt_clr, busy, done,
           result_count, result_sum, err_stall
  );

  modport slave (
    input  active, start, cfg_a, cfg_b, cfg_gate, ring_cnt, adder_sum,
    output adder_a, adder_b, ring_en, ring_cnt_clr, busy, done,
           result_count, result_sum, err_stall
  );
endinterface

// File: rtl/instrumented_adder_meas_ctrl.sv
// Sequencer for one ring-oscillator timing measurement of the instrumented adder.
// Optional MEAS_CTRL_ACCUM_EN: repeat 2**REPEAT_LOG2 runs per start and accumulate counts.
module instrumented_adder_meas_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CAPTURE_DELAY = 2,
  parameter int GATE_W        = 16,
  parameter int REPEAT_LOG2   = 2
) (
  input logic                           wb_clk_i,
  input logic                           wb_rst_i,
  instrumented_adder_meas_ctrl_if.slave bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || CAPTURE_DELAY < 1 || REPEAT_LOG2 < 1)
    begin : g_bad_param
      $error("instrumented_adder_meas_ctrl: parameter out of range");
    end

  typedef enum logic [2:0] {IDLE, SETTLE, RUN, CAPTURE, DONE} state_t;

  state_t            state;
  logic [31:0]       cnt;
  logic [GATE_W-1:0] gate;
  logic              start_ok;

  assign start_ok = bus.start && (bus.cfg_gate != '0);

`ifdef MEAS_CTRL_ACCUM_EN
  logic [REPEAT_LOG2-1:0] rep;
  logic [32:0]            acc;
  logic [31:0]            acc_sat;
  assign acc     = {1'b0, bus.result_count} + {1'b0, bus.ring_cnt};
  assign acc_sat = acc[32] ? 32'hFFFF_FFFF : acc[31:0];
`endif

  always_ff @(posedge wb_clk_i) begin
    // active low behaves exactly like reset: abort and clear everything
    if (wb_rst_i || !bus.active) begin
      state            <= IDLE;
      cnt              <= '0;
      gate             <= '0;
      bus.adder_a      <= '0;
      bus.adder_b      <= '0;
      bus.ring_en      <= 1'b0;
      bus.ring_cnt_clr <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.result_count <= '0;
      bus.result_sum   <= '0;
      bus.err_stall    <= 1'b0;
`ifdef MEAS_CTRL_ACCUM_EN
      rep              <= '0;
`endif
    end else begin
      bus.ring_cnt_clr <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state            <= SETTLE;
            cnt              <= 32'(SETTLE_CYCLES - 1);
            gate             <= bus.cfg_gate;
            bus.adder_a      <= bus.cfg_a;
            bus.adder_b      <= bus.cfg_b;
            bus.ring_cnt_clr <= 1'b1;
            bus.busy         <= 1'b1;
            bus.done         <= 1'b0;
`ifdef MEAS_CTRL_ACCUM_EN
            rep              <= '0;
            bus.result_count <= '0;
            bus.err_stall    <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state       <= RUN;
            bus.ring_en <= 1'b1;
            cnt         <= 32'(gate) - 32'd1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state       <= CAPTURE;
            bus.ring_en <= 1'b0;
            cnt         <= 32'(CAPTURE_DELAY - 1);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        CAPTURE: begin
          if (cnt == '0) begin
            bus.result_sum <= bus.adder_sum;
`ifdef MEAS_CTRL_ACCUM_EN
            bus.result_count <= acc_sat;
            bus.err_stall    <= bus.err_stall | (bus.ring_cnt == '0);
            if (rep != '1) begin
              rep              <= rep + 1'b1;
              state            <= SETTLE;
              cnt              <= 32'(SETTLE_CYCLES - 1);
              bus.ring_cnt_clr <= 1'b1;
            end else begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
`else
            bus.result_count <= bus.ring_cnt;
            bus.err_stall    <= (bus.ring_cnt == '0);
            state            <= DONE;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instrumented_adder_meas_ctrl.sv
// Directed scoreboard bench for instrumented_adder_meas_ctrl with a ring-counter/adder model.
module tb_instrumented_adder_meas_ctrl;

`ifdef MEAS_CTRL_ACCUM_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif
  localparam int SETTLE = 4;
  localparam int CD     = 2;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] sum;
    logic        err;
    int          lat;
    int          en_cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs    = 0;
  exp_t sb[$];

  logic [31:0] ring = '0;
  logic        stuck = 1'b0;
  logic        big   = 1'b0;

  instrumented_adder_meas_ctrl_if #(.GATE_W(16)) bus ();

  instrumented_adder_meas_ctrl #(
    .SETTLE_CYCLES(SETTLE), .CAPTURE_DELAY(CD), .GATE_W(16), .REPEAT_LOG2(2)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // wrapper ring counter: cleared by ring_cnt_clr, counts once per cycle while enabled
  always @(posedge clk) begin
    if (bus.ring_cnt_clr) ring <= '0;
    else if (bus.ring_en) ring <= ring + 32'd1;
  end
  assign bus.ring_cnt  = big ? 32'hC000_0000 : (stuck ? 32'd0 : ring);
  assign bus.adder_sum = bus.adder_a + bus.adder_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sat_total(input logic [31:0] per_run);
    longint t;
    t = longint'(REPS) * longint'(per_run);
    return (t > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  // one measurement; poke=1 fires extra start pulses mid-flight that must be ignored
  task automatic run_meas(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] g, input logic [31:0] exp_cnt,
                          input logic exp_err, input bit poke);
    exp_t e;
    int cyc, en, clr, overlap;
    e.cnt = exp_cnt; e.sum = a + b; e.err = exp_err;
    e.lat = REPS * (SETTLE + int'(g) + CD);
    e.en_cycles = REPS * int'(g);
    sb.push_back(e);
    bus.cfg_a = a; bus.cfg_b = b; bus.cfg_gate = g; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0; en = 0; clr = 0; overlap = 0;
    while (!bus.done && cyc < 2000) begin
      if (bus.ring_en) en++;
      if (bus.ring_cnt_clr) clr++;
      if (bus.busy && bus.done) overlap++;
      bus.start = poke && (cyc == 2 || cyc == 8);
      bus.cfg_a = bus.start ? 32'd100 : a;
      step();
      bus.start = 1'b0;
      bus.cfg_a = a;
      cyc++;
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_ring_en_cycles"}, 32'(en), 32'(e.en_cycles));
    chk({tag, "_clr_pulses"}, 32'(clr), 32'(REPS));
    chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_result_count"}, bus.result_count, e.cnt);
    chk({tag, "_result_sum"}, bus.result_sum, e.sum);
    chk({tag, "_err_stall"}, {31'd0, bus.err_stall}, {31'd0, e.err});
    chk({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_adder_a"}, bus.adder_a, a);
  endtask

  initial begin
    bus.active = 1'b1; bus.start = 1'b0;
    bus.cfg_a = '0; bus.cfg_b = '0; bus.cfg_gate = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_ring_en", {31'd0, bus.ring_en}, 32'd0);
    chk("reset_result_count", bus.result_count, 32'd0);

    run_meas("basic", 32'd3, 32'd5, 16'd10, sat_total(32'd10), 1'b0, 1'b0);

    // reset while the ring is running
    bus.cfg_a = 32'd1; bus.cfg_b = 32'd2; bus.cfg_gate = 16'd10; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    chk("midrun_ring_en", {31'd0, bus.ring_en}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_midrun_ring_en", {31'd0, bus.ring_en}, 32'd0);
    chk("rst_midrun_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_midrun_done", {31'd0, bus.done}, 32'd0);
    chk("rst_midrun_result_count", bus.result_count, 32'd0);

    // zero gate window is not a valid start
    bus.cfg_gate = 16'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("gate0_busy", {31'd0, bus.busy}, 32'd0);
    chk("gate0_clr", {31'd0, bus.ring_cnt_clr}, 32'd0);
    step();
    chk("gate0_still_idle", {31'd0, bus.busy}, 32'd0);

    stuck = 1'b1;
    run_meas("stuck", 32'd20, 32'd22, 16'd5, 32'd0, 1'b1, 1'b0);
    stuck = 1'b0;

    run_meas("ignored_starts", 32'd7, 32'd9, 16'd6, sat_total(32'd6), 1'b0, 1'b1);

    // deselect during CAPTURE aborts without done
    bus.cfg_a = 32'd4; bus.cfg_b = 32'd4; bus.cfg_gate = 16'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (SETTLE + 3) step();
    bus.active = 1'b0;
    step();
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_adder_a", bus.adder_a, 32'd0);
    bus.active = 1'b1;
    repeat (5) step();
    chk("abort_no_done_later", {31'd0, bus.done}, 32'd0);
    chk("abort_ring_en", {31'd0, bus.ring_en}, 32'd0);

`ifdef MEAS_CTRL_ACCUM_EN
    big = 1'b1;
    run_meas("saturate", 32'd1, 32'd1, 16'd4, sat_total(32'hC000_0000), 1'b0, 1'b0);
    big = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
